// File: rtl/barrel_shifter_pipe_if.sv
// Streaming handshake bundle for barrel_shifter_pipe: input word with shift controls,
// and the shifted result, each side using valid/ready.
interface barrel_shifter_pipe_if #(
    parameter int WIDTH = 32
) ();
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shift_value;
    logic               is_shift_right;
    logic [1:0]         mode;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   shifted_data;

    modport master (
        output in_valid, data, shift_value, is_shift_right, mode, out_ready,
        input  in_ready, out_valid, shifted_data
    );

    modport slave (
        input  in_valid, data, shift_value, is_shift_right, mode, out_ready,
        output in_ready, out_valid, shifted_data
    );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: stage k shifts by 2^k when shift bit k is set.
// Logical, arithmetic and rotate modes in both directions, valid/ready on both sides.
module barrel_shifter_pipe #(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    barrel_shifter_pipe_if.slave   bus
);
    localparam int         LAST       = SHAMT_W - 1;
    localparam logic [1:0] MODE_ARITH = 2'b01;
    localparam logic [1:0] MODE_ROT   = 2'b10;

    logic [WIDTH-1:0]   dataQ    [SHAMT_W];
    logic [SHAMT_W-1:0] validQ;
    logic [SHAMT_W-1:0] shamtQ   [SHAMT_W-1];
    logic [1:0]         modeQ    [SHAMT_W-1];
    logic [SHAMT_W-2:0] dirQ;
    logic [SHAMT_W-2:0] signQ;

    logic [SHAMT_W-1:0] stageLoad;
    logic               inReady;

    logic [WIDTH-1:0]   srcData  [SHAMT_W];
    logic [SHAMT_W-1:0] srcShamt [SHAMT_W];
    logic [1:0]         srcMode  [SHAMT_W];
    logic [SHAMT_W-1:0] srcDir;
    logic [SHAMT_W-1:0] srcSign;
    logic [SHAMT_W-1:0] srcValid;
    logic [WIDTH-1:0]   dataD    [SHAMT_W];

    // A stage may load when empty or when its word moves on this same cycle,
    // so ready ripples back from out_ready and bubbles collapse.
    always_comb begin
        stageLoad       = '0;
        stageLoad[LAST] = !validQ[LAST] || bus.out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            stageLoad[k] = !validQ[k] || stageLoad[k+1];
        end
    end

    assign inReady = reset && stageLoad[0];

    always_comb begin
        srcData[0]  = bus.data;
        srcShamt[0] = bus.shift_value;
        srcMode[0]  = bus.mode;
        srcDir      = '0;
        srcSign     = '0;
        srcValid    = '0;
        srcDir[0]   = bus.is_shift_right;
        srcSign[0]  = bus.data[WIDTH-1];
        srcValid[0] = bus.in_valid && inReady;
        for (int k = 1; k < SHAMT_W; k++) begin
            srcData[k]  = dataQ[k-1];
            srcShamt[k] = shamtQ[k-1];
            srcMode[k]  = modeQ[k-1];
            srcDir[k]   = dirQ[k-1];
            srcSign[k]  = signQ[k-1];
            srcValid[k] = validQ[k-1];
        end
    end

    // The original sign bit travels with the word so every arithmetic stage
    // fills from it, not from the partially shifted intermediate.
    always_comb begin
        int               amt;
        logic [WIDTH-1:0] word;
        logic [WIDTH-1:0] fill;
        amt  = 0;
        word = '0;
        fill = '0;
        for (int k = 0; k < SHAMT_W; k++) begin
            amt      = 1 << k;
            word     = srcData[k];
            fill     = (srcSign[k] && (srcMode[k] == MODE_ARITH)) ? ~({WIDTH{1'b1}} >> amt) : '0;
            dataD[k] = word;
            if (srcShamt[k][k]) begin
                if (srcMode[k] == MODE_ROT) begin
                    dataD[k] = srcDir[k] ? ((word >> amt) | (word << (WIDTH - amt)))
                                         : ((word << amt) | (word >> (WIDTH - amt)));
                end else if (srcDir[k]) begin
                    dataD[k] = (word >> amt) | fill;
                end else begin
                    dataD[k] = word << amt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            validQ <= '0;
            dirQ   <= '0;
            signQ  <= '0;
            for (int k = 0; k < SHAMT_W; k++) begin
                dataQ[k] <= '0;
            end
            for (int k = 0; k < SHAMT_W - 1; k++) begin
                shamtQ[k] <= '0;
                modeQ[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < SHAMT_W; k++) begin
                if (stageLoad[k]) begin
                    validQ[k] <= srcValid[k];
                    if (srcValid[k]) begin
                        dataQ[k] <= dataD[k];
                    end
                end
            end
            // The last stage needs no control fields; only its word is presented.
            for (int k = 0; k < SHAMT_W - 1; k++) begin
                if (stageLoad[k] && srcValid[k]) begin
                    shamtQ[k] <= srcShamt[k];
                    modeQ[k]  <= srcMode[k];
                    dirQ[k]   <= srcDir[k];
                    signQ[k]  <= srcSign[k];
                end
            end
        end
    end

    assign bus.in_ready     = inReady;
    assign bus.out_valid    = validQ[LAST];
    assign bus.shifted_data = dataQ[LAST];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe: directed vectors, random streams
// with backpressure checked against a plain-arithmetic shift model, and mid-flight reset.
module tb_barrel_shifter_pipe;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = $clog2(WIDTH);

    logic clk = 1'b0;
    logic reset;
    int   checkCount = 0;
    int   failCount  = 0;

    barrel_shifter_pipe_if #(.WIDTH(WIDTH)) bus ();

    barrel_shifter_pipe #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] refShift(input logic [WIDTH-1:0] d, input int amt,
                                                  input bit right, input logic [1:0] m);
        if (amt == 0) return d;
        if (m == 2'b10) return right ? ((d >> amt) | (d << (WIDTH - amt)))
                                     : ((d << amt) | (d >> (WIDTH - amt)));
        if (right && m == 2'b01) return $signed(d) >>> amt;
        return right ? (d >> amt) : (d << amt);
    endfunction

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit valid, input logic [WIDTH-1:0] d, input int amt,
                                 input bit right, input logic [1:0] m);
        bus.in_valid       = valid;
        bus.data           = d;
        bus.shift_value    = SHAMT_W'(amt);
        bus.is_shift_right = right;
        bus.mode           = m;
    endtask

    // One word in an empty pipe; checks acceptance, latency and result.
    task automatic directed(input string tag, input logic [WIDTH-1:0] d, input int amt,
                            input bit right, input logic [1:0] m, input logic [WIDTH-1:0] exp);
        int lat;
        @(negedge clk);
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, d, amt, right, m);
        #2;
        checkOutput({tag, "_accept"}, {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            #2;
            if (bus.out_valid) begin
                lat = c;
                break;
            end
        end
        checkOutput({tag, "_latency"}, lat, SHAMT_W);
        checkOutput({tag, "_data"}, bus.shifted_data, exp);
        @(negedge clk);
    endtask

    // Random stream against a scoreboard queue; out_ready held low for the first
    // blockCycles cycles, then random with readyPct.
    task automatic runStream(input string tag, input int nWords, input int validPct,
                             input int readyPct, input int blockCycles, input int maxCycles);
        logic [WIDTH-1:0] expQ[$];
        logic [WIDTH-1:0] curData;
        logic [WIDTH-1:0] holdData;
        logic [1:0]       curMode;
        int               curAmt;
        bit               curRight;
        bit               holdValid;
        int               sent;
        int               received;
        int               cycles;
        sent      = 0;
        received  = 0;
        cycles    = 0;
        holdValid = 1'b0;
        holdData  = '0;
        curData   = $urandom;
        curAmt    = $urandom_range(WIDTH - 1);
        curRight  = 1'($urandom_range(1));
        curMode   = 2'($urandom_range(3));
        while (received < nWords && cycles < maxCycles) begin
            @(negedge clk);
            cycles++;
            applyStimulus((sent < nWords) && ($urandom_range(99) < validPct),
                          curData, curAmt, curRight, curMode);
            bus.out_ready = (cycles > blockCycles) && ($urandom_range(99) < readyPct);
            #2;
            if (holdValid) checkOutput({tag, "_stall_hold"}, bus.shifted_data, holdData);
            holdValid = bus.out_valid && !bus.out_ready;
            holdData  = bus.shifted_data;
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput({tag, "_spurious"}, 32'd1, 32'd0);
                end else begin
                    checkOutput({tag, "_data"}, bus.shifted_data, expQ.pop_front());
                end
                received++;
            end
            if (bus.in_valid && bus.in_ready) begin
                expQ.push_back(refShift(curData, curAmt, curRight, curMode));
                sent++;
                curData  = $urandom;
                curAmt   = $urandom_range(WIDTH - 1);
                curRight = 1'($urandom_range(1));
                curMode  = 2'($urandom_range(3));
            end
            if (blockCycles > 0 && cycles == blockCycles) begin
                checkOutput({tag, "_bp_accepted"}, sent, SHAMT_W);
                checkOutput({tag, "_bp_in_ready"}, {31'b0, bus.in_ready}, 32'd0);
            end
        end
        checkOutput({tag, "_received"}, received, nWords);
        checkOutput({tag, "_leftover"}, expQ.size(), 32'd0);
        if (validPct == 100 && readyPct == 100 && blockCycles == 0)
            checkOutput({tag, "_throughput_cycles"}, cycles, nWords + SHAMT_W);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int ghosts;
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 32'hFFFF_FFFF, 3, 1'b0, 2'b00);

        repeat (2) @(negedge clk);
        #2;
        checkOutput("reset_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
        checkOutput("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("reset_data", bus.shifted_data, 32'd0);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        #2;
        checkOutput("post_reset_in_ready", {31'b0, bus.in_ready}, 32'd1);

        directed("lsl1",      32'h0000_0060, 1,  1'b0, 2'b00, 32'h0000_00C0);
        directed("lsr1",      32'h0000_0060, 1,  1'b1, 2'b00, 32'h0000_0030);
        directed("lsr10",     32'h0000_0060, 10, 1'b1, 2'b00, 32'h0000_0000);
        directed("asr4",      32'h8000_0060, 4,  1'b1, 2'b01, 32'hF800_0006);
        directed("lsr4",      32'h8000_0060, 4,  1'b1, 2'b00, 32'h0800_0006);
        directed("asl3",      32'h0000_0060, 3,  1'b0, 2'b01, 32'h0000_0300);
        directed("ror1",      32'h0000_0061, 1,  1'b1, 2'b10, 32'h8000_0030);
        directed("rol31",     32'h8000_0001, 31, 1'b0, 2'b10, 32'hC000_0000);
        directed("rot0",      32'h1234_5678, 0,  1'b1, 2'b10, 32'h1234_5678);
        directed("mode11_r4", 32'h8000_0060, 4,  1'b1, 2'b11, 32'h0800_0006);
        directed("asr31",     32'h8000_0000, 31, 1'b1, 2'b01, 32'hFFFF_FFFF);

        runStream("stream_full", 16, 100, 100, 0, 200);
        runStream("stream_rand", 40, 70, 50, 0, 2000);
        runStream("backpressure", 8, 100, 100, 10, 200);

        // Three words in flight, then a one-cycle reset must discard them.
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'hDEAD_0001 + i, 0, 1'b0, 2'b00);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #2;
        checkOutput("midreset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("midreset_data", bus.shifted_data, 32'd0);
        checkOutput("midreset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        ghosts = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #2;
            if (bus.out_valid) ghosts++;
        end
        checkOutput("midreset_ghosts", ghosts, 32'd0);
        directed("after_reset", 32'h0000_0061, 1, 1'b1, 2'b10, 32'h8000_0030);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
